// File: rtl/tc_io_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tc_io_pad_ctrl
// Purpose  : Configuration sequencer for a bank of digital IO pad cells.
//            Holds per-pad direction, drive strength and pulls. Any change
//            is applied break-before-make: the pad is first floated, held
//            for a settle window, then loaded with its new configuration.
//            Also drives the shared retention-enable (rte) signal.
// Revision : 1.0 - initial release
// ============================================================================
module tc_io_pad_ctrl #(
  parameter  int NumPads       = 8,
  parameter  int SettleCycles  = 4,
  parameter  int RteHoldCycles = 16,
  localparam int PadIdxW       = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  output logic                 cfg_gnt_o,
  input  logic [PadIdxW-1:0]   cfg_pad_i,
  input  logic                 cfg_oe_n_i,
  input  logic [3:0]           cfg_drv_i,
  input  logic                 cfg_pu_i,
  input  logic                 cfg_pd_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 rte_o,
  output logic [NumPads-1:0]   pad_oe_n_o,
  output logic [4*NumPads-1:0] pad_drv_o,
  output logic [NumPads-1:0]   pad_pu_o,
  output logic [NumPads-1:0]   pad_pd_o
);

  // One counter serves both the rte hold in INIT and the settle hold in FLOAT.
  localparam int c_cnt_max = ((RteHoldCycles - 1) > SettleCycles) ? (RteHoldCycles - 1)
                                                                   : SettleCycles;
  localparam int c_cnt_w   = (c_cnt_max > 0) ? $clog2(c_cnt_max + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_rte_load    = c_cnt_w'(RteHoldCycles - 1);
  localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SettleCycles);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLOAT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_rte;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_req_valid;
  logic                 w_do_float;
  logic                 w_do_err;
  logic                 w_do_load;

  logic [PadIdxW-1:0]   r_cap_pad;
  logic                 r_cap_oe_n;
  logic [3:0]           r_cap_drv;
  logic                 r_cap_pu;
  logic                 r_cap_pd;

  logic [NumPads-1:0]   r_oe_n;
  logic [4*NumPads-1:0] r_drv;
  logic [NumPads-1:0]   r_pu;
  logic [NumPads-1:0]   r_pd;

  // A request is rejected for conflicting pulls or an out-of-range pad index.
  assign w_req_valid = ~(cfg_pu_i & cfg_pd_i) & (32'(cfg_pad_i) < 32'(NumPads));
  assign cfg_gnt_o   = (r_state == IDLE) & cfg_req_i;

  // Next-state, counter and per-edge action decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_do_float  = 1'b0;
    w_do_err    = 1'b0;
    w_do_load   = 1'b0;
    case (r_state)
      INIT: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      IDLE: begin
        if (cfg_req_i) begin
          if (w_req_valid) begin
            w_do_float  = 1'b1;
            w_state_nxt = FLOAT;
            w_cnt_nxt   = c_settle_load;
          end else begin
            w_do_err    = 1'b1;
          end
        end
      end
      FLOAT: begin
        if (r_cnt == '0) begin
          w_do_load   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = c_rte_load;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= INIT;
      r_cnt   <= c_rte_load;
      r_rte   <= 1'b1;
      r_busy  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rte   <= (w_state_nxt == INIT);
      r_busy  <= (w_state_nxt != IDLE);
      r_err   <= w_do_err;
    end
  end

  // Capture the granted request; only meaningful while the sequence runs.
  always_ff @(posedge clk_i) begin
    if (w_do_float) begin
      r_cap_pad  <= cfg_pad_i;
      r_cap_oe_n <= cfg_oe_n_i;
      r_cap_drv  <= cfg_drv_i;
      r_cap_pu   <= cfg_pu_i;
      r_cap_pd   <= cfg_pd_i;
    end
  end

  // Per-pad settings: float the target on grant, load it on FLOAT exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_oe_n <= '1;
      r_drv  <= '0;
      r_pu   <= '0;
      r_pd   <= '0;
    end else begin
      for (int k = 0; k < NumPads; k++) begin
        if (w_do_float && (cfg_pad_i == PadIdxW'(k))) begin
          r_oe_n[k] <= 1'b1;
          r_pu[k]   <= 1'b0;
          r_pd[k]   <= 1'b0;
        end else if (w_do_load && (r_cap_pad == PadIdxW'(k))) begin
          r_oe_n[k]         <= r_cap_oe_n;
          r_drv[4*k +: 4]   <= r_cap_drv;
          r_pu[k]           <= r_cap_pu;
          r_pd[k]           <= r_cap_pd;
        end
      end
    end
  end

  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign rte_o      = r_rte;
  assign pad_oe_n_o = r_oe_n;
  assign pad_drv_o  = r_drv;
  assign pad_pu_o   = r_pu;
  assign pad_pd_o   = r_pd;

endmodule
`default_nettype wire
